uart_packet_tx_arbiter: RTL and testbench

- Shares the single UART transmit packet stream between N packet sources, e.g. register control and streaming/telemetry blocks.
- Arbitration is packet-granular round-robin. A grant is held from the SoP beat through the EoP beat, so packets never interleave.
- Sits between the sources and the UART packetiser/transmitter.
- Also drops orphan beats and aborts stalled packets via a watchdog.

---
 rtl/uart_packet_tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_uart_packet_tx_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_packet_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one UART TX stream; 1-cycle registered latency.
// Backpressure: the granted source sees ready only while the one-beat output register can take a beat.
package uart_packet_pkg;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } uart_packet_t;
endpackage

module uart_packet_tx_arbiter
    import uart_packet_pkg::*;
#(
    parameter int N       = 2,
    parameter int TIMEOUT = 4096,
    localparam int GW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 ipClk,
    input  logic                 ipReset,
    input  uart_packet_t [N-1:0] ipStream,
    output logic [N-1:0]         opReady,
    output uart_packet_t         opTxStream,
    input  logic                 ipTxReady,
    output logic [GW-1:0]        opGrant,
    output logic                 opBusy,
    output logic [7:0]           opDropCount,
    output logic [7:0]           opAbortCount
);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state_q, state_d;
    uart_packet_t  tx_q, tx_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic [7:0]    drop_q, drop_d;
    logic [7:0]    abort_q, abort_d;

    logic [N-1:0]  sop_req, orphan;
    logic          found;
    logic [GW-1:0] pick, idx;
    logic [9:0]    drop_sum;
    logic          out_free, beat_xfer;
    uart_packet_t  gbeat;

    assign gbeat     = ipStream[grant_q];
    assign out_free  = ~tx_q.Valid | ipTxReady;
    assign beat_xfer = (state_q == LOCKED) & gbeat.Valid & out_free;

    // Round-robin scan starting just after the last grant, plus orphan tally for IDLE.
    always_comb begin
        found    = 1'b0;
        pick     = grant_q;
        idx      = '0;
        drop_sum = {2'b00, drop_q};
        for (int i = 0; i < N; i++) begin
            sop_req[i] = ipStream[i].Valid & ipStream[i].SoP;
            orphan[i]  = ipStream[i].Valid & ~ipStream[i].SoP;
            if (orphan[i]) drop_sum = drop_sum + 10'd1;
        end
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(grant_q) + k) % N);
            if (!found && sop_req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge ipClk or negedge ipReset) begin
        if (!ipReset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            grant_q <= GW'(N - 1);
            wdog_q  <= '0;
            drop_q  <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            grant_q <= grant_d;
            wdog_q  <= wdog_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        wdog_d  = wdog_q;
        drop_d  = drop_q;
        abort_d = abort_q;
        tx_d    = tx_q;
        if (tx_q.Valid && ipTxReady) tx_d.Valid = 1'b0;
        case (state_q)
            IDLE: begin
                wdog_d = '0;
                drop_d = (drop_sum > 10'd255) ? 8'hFF : drop_sum[7:0];
                if (found) begin
                    grant_d = pick;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (beat_xfer) begin
                    tx_d   = gbeat;
                    wdog_d = '0;
                    if (gbeat.EoP) state_d = IDLE;
                end else if (!gbeat.Valid) begin
                    // Only a silent source ages the watchdog; a downstream stall does not.
                    if (wdog_q == WW'(TIMEOUT - 1)) begin
                        wdog_d  = '0;
                        state_d = IDLE;
                        if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opReady = '0;
        opBusy  = (state_q == LOCKED);
        if (state_q == IDLE) opReady = orphan;
        else                 opReady[grant_q] = out_free;
        if (!ipReset) opReady = '0;
    end

    assign opTxStream   = tx_q;
    assign opGrant      = grant_q;
    assign opDropCount  = drop_q;
    assign opAbortCount = abort_q;
endmodule

// File: tb/tb_uart_packet_tx_arbiter.sv
// Directed bench for uart_packet_tx_arbiter: expected beats queued up front, negedge monitor pops and compares.
module tb_uart_packet_tx_arbiter;
    import uart_packet_pkg::*;

    localparam int N       = 2;
    localparam int TIMEOUT = 4096;
    localparam int BUDGET  = 6000;

    logic                 ipClk = 1'b0;
    logic                 ipReset;
    logic                 ipTxReady;
    uart_packet_t         src [N];
    uart_packet_t [N-1:0] stream_w;
    logic [N-1:0]         opReady;
    uart_packet_t         opTxStream;
    logic [0:0]           opGrant;
    logic                 opBusy;
    logic [7:0]           opDropCount;
    logic [7:0]           opAbortCount;

    int           checks = 0;
    int           errors = 0;
    uart_packet_t sb [$];

    logic [7:0] d2 [5] = '{8'h12, 8'h17, 8'h1C, 8'h21, 8'h26};

    assign stream_w = {src[1], src[0]};
    always #5 ipClk = ~ipClk;

    uart_packet_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .ipClk       (ipClk),
        .ipReset     (ipReset),
        .ipStream    (stream_w),
        .opReady     (opReady),
        .opTxStream  (opTxStream),
        .ipTxReady   (ipTxReady),
        .opGrant     (opGrant),
        .opBusy      (opBusy),
        .opDropCount (opDropCount),
        .opAbortCount(opAbortCount)
    );

    function automatic uart_packet_t mk(input logic [7:0] s, input logic [7:0] d, input logic [7:0] len,
                                        input logic sop, input logic eop, input logic [7:0] data);
        uart_packet_t p;
        p.Source      = s;
        p.Destination = d;
        p.Length      = len;
        p.SoP         = sop;
        p.EoP         = eop;
        p.Data        = data;
        p.Valid       = 1'b1;
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tx"},    64'(opTxStream),   64'd0);
        chk({tag, "_ready"}, 64'(opReady),      64'd0);
        chk({tag, "_grant"}, 64'(opGrant),      64'(N - 1));
        chk({tag, "_busy"},  64'(opBusy),       64'd0);
        chk({tag, "_drop"},  64'(opDropCount),  64'd0);
        chk({tag, "_abort"}, 64'(opAbortCount), 64'd0);
    endtask

    // Present a beat on source s and hold it until it is accepted.
    task automatic send(input bit s, input uart_packet_t b);
        int n;
        src[s] = b;
        n = 0;
        do begin
            @(negedge ipClk);
            n++;
        end while (!opReady[s] && n < BUDGET);
        if (!opReady[s]) begin
            checks++;
            errors++;
            $display("FAIL handshake_src%0d: opReady stayed 0, required 1 within %0d cycles", s, BUDGET);
        end
        @(posedge ipClk);
        #1;
        src[s] = '0;
    endtask

    task automatic monitor();
        uart_packet_t exp;
        forever begin
            @(negedge ipClk);
            if (ipReset && opTxStream.Valid && ipTxReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got beat src %0d data 0x%0h, required no beat",
                             opTxStream.Source, opTxStream.Data);
                end else begin
                    exp = sb.pop_front();
                    if (opTxStream !== exp) begin
                        errors++;
                        $display("FAIL sb_beat: got 0x%0h, required 0x%0h", opTxStream, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        uart_packet_t b0, b1, c1, o, a0, a1, r0, r1, s0;
        uart_packet_t p [5];
        int n;

        ipReset   = 1'b1;
        ipTxReady = 1'b1;
        src[0]    = '0;
        src[1]    = '0;
        fork
            monitor();
        join_none
        #1 ipReset = 1'b0;
        #2 check_reset("rst0");
        repeat (3) @(posedge ipClk);
        #1 ipReset = 1'b1;
        @(posedge ipClk);
        #1;

        // Simultaneous single-beat packets: source 0 first, then source 1.
        b0 = mk(8'h00, 8'hA0, 8'd1, 1'b1, 1'b1, 8'h11);
        b1 = mk(8'h01, 8'hA1, 8'd1, 1'b1, 1'b1, 8'h22);
        sb.push_back(b0);
        sb.push_back(b1);
        fork
            begin send(1'b0, b0); chk("t1_grant0", 64'(opGrant), 64'd0); end
            begin send(1'b1, b1); chk("t1_grant1", 64'(opGrant), 64'd1); end
        join
        repeat (4) @(posedge ipClk);
        #1 chk("t1_drained", 64'(sb.size()), 64'd0);

        // Five-beat packet is not interleaved by a mid-packet request from source 1.
        for (int i = 0; i < 5; i++) begin
            p[i] = mk(8'h00, 8'hB0, 8'd5, i == 0, i == 4, d2[i]);
            sb.push_back(p[i]);
        end
        c1 = mk(8'h01, 8'hB1, 8'd1, 1'b1, 1'b1, 8'h99);
        sb.push_back(c1);
        fork
            begin for (int i = 0; i < 5; i++) send(1'b0, p[i]); end
            begin repeat (4) @(posedge ipClk); #1; send(1'b1, c1); end
            begin
                repeat (4) @(posedge ipClk);
                repeat (3) begin
                    @(negedge ipClk);
                    chk("t2_rdy1_low", 64'(opReady[1]), 64'd0);
                end
            end
        join
        repeat (4) @(posedge ipClk);
        #1 chk("t2_drained", 64'(sb.size()), 64'd0);

        // Downstream stall during a five-beat packet.
        for (int i = 0; i < 5; i++) begin
            p[i] = mk(8'h00, 8'hC0, 8'd5, i == 0, i == 4, 8'h30 + 8'(i));
            sb.push_back(p[i]);
        end
        fork
            begin for (int i = 0; i < 5; i++) send(1'b0, p[i]); end
            begin
                n = 0;
                do begin
                    @(negedge ipClk);
                    n++;
                end while (!(opTxStream.Valid && opTxStream.Data == 8'h31) && n < BUDGET);
                chk("t3_sync", 64'(opTxStream.Data), 64'h31);
                @(posedge ipClk);
                #1 ipTxReady = 1'b0;
                repeat (2) @(negedge ipClk);
                chk("t3_hold_early_data", 64'(opTxStream.Data), 64'h32);
                chk("t3_hold_early_vld",  64'(opTxStream.Valid), 64'd1);
                chk("t3_rdy0_early",      64'(opReady[0]), 64'd0);
                repeat (260) @(negedge ipClk);
                chk("t3_hold_late_data",  64'(opTxStream.Data), 64'h32);
                chk("t3_rdy0_late",       64'(opReady[0]), 64'd0);
                @(posedge ipClk);
                #1 ipTxReady = 1'b1;
            end
        join
        repeat (4) @(posedge ipClk);
        #1 chk("t3_drained", 64'(sb.size()), 64'd0);

        // Orphan beat in IDLE is swallowed and counted.
        o = mk(8'h01, 8'hD1, 8'd1, 1'b0, 1'b0, 8'h55);
        send(1'b1, o);
        chk("t4_drop_count", 64'(opDropCount), 64'd1);
        chk("t4_busy",       64'(opBusy), 64'd0);
        @(negedge ipClk);
        chk("t4_rdy1_one_cycle", 64'(opReady[1]), 64'd0);
        repeat (3) @(negedge ipClk);
        chk("t4_no_output", 64'(opTxStream.Valid), 64'd0);

        // Watchdog abort after a silent source, then the waiting source is served.
        a0 = mk(8'h00, 8'hE0, 8'd3, 1'b1, 1'b0, 8'h40);
        a1 = mk(8'h01, 8'hE1, 8'd1, 1'b1, 1'b1, 8'h41);
        sb.push_back(a0);
        sb.push_back(a1);
        send(1'b0, a0);
        fork
            begin send(1'b1, a1); chk("t5_grant_src1", 64'(opGrant), 64'd1); end
            begin
                repeat (TIMEOUT - 1) @(posedge ipClk);
                #1;
                chk("t5_busy_before",  64'(opBusy), 64'd1);
                chk("t5_abort_before", 64'(opAbortCount), 64'd0);
                @(posedge ipClk);
                #1;
                chk("t5_busy_after",   64'(opBusy), 64'd0);
                chk("t5_abort_after",  64'(opAbortCount), 64'd1);
                chk("t5_grant_kept",   64'(opGrant), 64'd0);
            end
        join
        repeat (4) @(posedge ipClk);
        #1 chk("t5_drained", 64'(sb.size()), 64'd0);

        // Reset mid-packet with a beat stalled in the output register.
        r0 = mk(8'h00, 8'hF0, 8'd4, 1'b1, 1'b0, 8'h60);
        r1 = mk(8'h00, 8'hF0, 8'd4, 1'b0, 1'b0, 8'h61);
        sb.push_back(r0);
        send(1'b0, r0);
        send(1'b0, r1);
        ipTxReady = 1'b0;
        #2 ipReset = 1'b0;
        #1 check_reset("rst1");
        @(posedge ipClk);
        #1;
        ipReset   = 1'b1;
        ipTxReady = 1'b1;
        s0 = mk(8'h00, 8'hF1, 8'd1, 1'b1, 1'b1, 8'h70);
        sb.push_back(s0);
        send(1'b0, s0);
        chk("t6_grant_src0", 64'(opGrant), 64'd0);
        repeat (4) @(posedge ipClk);
        #1 chk("t6_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
